// File: rtl/cv32e40s_mpu_arb.sv
// Purpose : arbitrates two requesters (0 = LSU, 1 = aux sequencer) onto one MPU request
//           channel, tracks outstanding ids and routes in-order responses back to their owner.
// Ports   : clk/rst_n; req{0,1}_valid_i/_trans_i/_ready_o; mpu_trans_valid_o/_o/_ready_i;
//           mpu_resp_valid_i/_i; resp{0,1}_valid_o, resp_o; one_txn_pend_n_o; outstanding_o.
// Latency : zero-cycle request and response paths. Backpressure: a presented, unaccepted grant
//           is locked until handshake; no request is offered once MAX_OUTSTANDING is reached
//           unless a response retires an entry in the same cycle.
// Config  : define CV32E40S_MPU_ARB_RR_EN for round-robin; default is fixed priority (req0 wins).
module cv32e40s_mpu_arb #(
   parameter int TRANS_W         = 72,
   parameter int RESP_W          = 40,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid_i,
   input  logic [TRANS_W-1:0] req0_trans_i,
   output logic               req0_ready_o,
   input  logic               req1_valid_i,
   input  logic [TRANS_W-1:0] req1_trans_i,
   output logic               req1_ready_o,
   output logic               mpu_trans_valid_o,
   output logic [TRANS_W-1:0] mpu_trans_o,
   input  logic               mpu_trans_ready_i,
   input  logic               mpu_resp_valid_i,
   input  logic [RESP_W-1:0]  mpu_resp_i,
   output logic               resp0_valid_o,
   output logic               resp1_valid_o,
   output logic [RESP_W-1:0]  resp_o,
   output logic               one_txn_pend_n_o,
   output logic [2:0]         outstanding_o
);

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   arb_state_t  r_state;
   logic        r_lock_id;
   logic [2:0]  r_count;
   logic [3:0]  r_fifo;      // owner id per outstanding slot, only [MAX_OUTSTANDING-1:0] used
   logic [1:0]  r_wptr;
   logic [1:0]  r_rptr;
`ifdef CV32E40S_MPU_ARB_RR_EN
   logic        r_prio;      // requester favoured on contention
`endif

   logic        w_pop;
   logic        w_room;
   logic        w_sel_id;
   logic        w_sel_vld;
   logic        w_accept;
   logic        w_head_id;
   logic [2:0]  w_count_after_pop;
   logic [2:0]  w_count_next;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // A response with nothing outstanding is ignored entirely.
   assign w_pop             = mpu_resp_valid_i && (r_count != 3'd0);
   assign w_count_after_pop = r_count - {2'b00, w_pop};
   // A retiring response frees its slot for a same-cycle accept.
   assign w_room            = w_count_after_pop < 3'(MAX_OUTSTANDING);

   always_comb begin
      w_sel_id = 1'b0;
      if (r_state == ARB_LOCK) begin
         w_sel_id = r_lock_id;
      end else if (req0_valid_i && req1_valid_i) begin
`ifdef CV32E40S_MPU_ARB_RR_EN
         w_sel_id = r_prio;
`else
         w_sel_id = 1'b0;
`endif
      end else begin
         w_sel_id = req1_valid_i;
      end
   end

   assign w_sel_vld         = w_sel_id ? req1_valid_i : req0_valid_i;
   assign mpu_trans_valid_o = w_sel_vld && w_room;
   assign mpu_trans_o       = mpu_trans_valid_o ? (w_sel_id ? req1_trans_i : req0_trans_i)
                                                : '0;
   assign w_accept          = mpu_trans_valid_o && mpu_trans_ready_i;
   assign req0_ready_o      = w_accept && !w_sel_id;
   assign req1_ready_o      = w_accept && w_sel_id;

   assign w_head_id         = r_fifo[r_rptr];
   assign resp_o            = mpu_resp_i;
   assign resp0_valid_o     = w_pop && !w_head_id;
   assign resp1_valid_o     = w_pop && w_head_id;

   assign w_count_next      = w_count_after_pop + {2'b00, w_accept};
   assign one_txn_pend_n_o  = (w_count_next == 3'd1);
   assign outstanding_o     = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ARB_IDLE;
         r_lock_id <= 1'b0;
         r_count   <= 3'd0;
         r_fifo    <= 4'd0;
         r_wptr    <= 2'd0;
         r_rptr    <= 2'd0;
`ifdef CV32E40S_MPU_ARB_RR_EN
         r_prio    <= 1'b0;
`endif
      end else begin
         // Grant locks only when actually presented and refused; a count-blocked
         // request leaves the state untouched so a held lock persists.
         if (r_state == ARB_IDLE) begin
            if (mpu_trans_valid_o && !mpu_trans_ready_i) begin
               r_state   <= ARB_LOCK;
               r_lock_id <= w_sel_id;
            end
         end else if (w_accept) begin
            r_state <= ARB_IDLE;
         end

         r_count <= w_count_next;

         if (w_accept) begin
            r_fifo[r_wptr] <= w_sel_id;
            r_wptr         <= ptr_inc(r_wptr);
`ifdef CV32E40S_MPU_ARB_RR_EN
            r_prio         <= ~w_sel_id;
`endif
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
      end
   end

endmodule
